// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per CALC cycle.
// DIV_SIGNED_EN selects two's-complement operands (truncating toward zero).
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   add_a, add_b;
  logic [WIDTH+1:0] add_s;
  logic             no_borrow;
  logic [WIDTH-1:0] step_rem, step_quo;
  logic [WIDTH-1:0] fin_quo, fin_rem;
  logic [WIDTH-1:0] zero_quo;
  logic [WIDTH-1:0] ld_dvd, ld_dvs;

  // Trial subtract: a + ~b + 1, carry-out set means no borrow
  assign add_a     = {rem_q, acc_q[WIDTH-1]};
  assign add_b     = {1'b0, dvs_q};
  assign add_s     = {1'b0, add_a} + {1'b0, ~add_b}
                   + {{(WIDTH+1){1'b0}}, 1'b1};
  assign no_borrow = add_s[WIDTH+1];
  assign step_rem  = no_borrow ? add_s[WIDTH-1:0]
                               : add_a[WIDTH-1:0];
  assign step_quo  = {acc_q[WIDTH-2:0], no_borrow};

`ifdef DIV_SIGNED_EN
  logic negq_q, negq_d;
  logic negr_q, negr_d;

  assign ld_dvd   = dividend[WIDTH-1] ? -dividend : dividend;
  assign ld_dvs   = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign fin_quo  = negq_q ? -step_quo : step_quo;
  assign fin_rem  = negr_q ? -step_rem : step_rem;
  assign zero_quo = dividend[WIDTH-1]
                  ? {1'b1, {(WIDTH-1){1'b0}}}
                  : {1'b0, {(WIDTH-1){1'b1}}};

  always_comb begin
    negq_d = negq_q;
    negr_d = negr_q;
    if (state_q == IDLE && start) begin
      negq_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      negr_d = dividend[WIDTH-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`else
  assign ld_dvd   = dividend;
  assign ld_dvs   = divisor;
  assign fin_quo  = step_quo;
  assign fin_rem  = step_rem;
  assign zero_quo = '1;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = zero_quo;
            rmd_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
            cnt_d   = '0;
            rem_d   = '0;
            acc_d   = ld_dvd;
            dvs_d   = ld_dvs;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        acc_d = step_quo;
        cnt_d = cnt_q + CW'(1);
        // Last iteration loads the results directly
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          quo_d   = fin_quo;
          rmd_d   = fin_rem;
          dbz_d   = 1'b0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      acc_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=32).
// Signed vectors are used when DIV_SIGNED_EN is defined.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        out_valid;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int n_cmp = 0;
  int n_bad = 0;

  seq_divider #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .out_valid   (out_valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Latency counts edges from the accept edge (inclusive)
  // up to the edge after which out_valid is seen.
  task automatic run_div(input string       tag,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [31:0] qe,
                         input logic [31:0] re,
                         input logic        dz,
                         input int          late);
    int n;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    while (!out_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, n, late);
    chk({tag, "_q"}, quotient, qe);
    chk({tag, "_r"}, remainder, re);
    chk({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, dz});
    @(negedge clk);
    chk({tag, "_pulse"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_hold"}, quotient, qe);
  endtask

  int          got;
  int          cyc;
  int          last;
  int          seen;
  logic [31:0] ea[$];
  logic [31:0] eb[$];
  logic [31:0] xa, xb;

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 32'd100;
    divisor  = 32'd7;
    repeat (3) @(negedge clk);
    chk("rst_start_ignored", {31'b0, busy}, 32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_q", quotient, 32'd0);
    chk("rst_r", remainder, 32'd0);
    chk("rst_dz", {31'b0, div_by_zero}, 32'd0);
    start = 1'b0;
    rst   = 1'b0;

    run_div("d100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
`ifdef DIV_SIGNED_EN
    run_div("dz_pos", 32'h12345678, 32'd0,
            32'h7FFFFFFF, 32'h12345678, 1'b1, 1);
    run_div("dz_neg", 32'h80000000, 32'd0,
            32'h80000000, 32'h80000000, 1'b1, 1);
    run_div("m7_2", 32'hFFFFFFF9, 32'd2,
            32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
    run_div("min_m1", 32'h80000000, 32'hFFFFFFFF,
            32'h80000000, 32'd0, 1'b0, 33);
    run_div("p7_m2", 32'd7, 32'hFFFFFFFE,
            32'hFFFFFFFD, 32'd1, 1'b0, 33);
    run_div("m100_m7", 32'hFFFFFF9C, 32'hFFFFFFF9,
            32'd14, 32'hFFFFFFFE, 1'b0, 33);
`else
    run_div("dz", 32'h12345678, 32'd0,
            32'hFFFFFFFF, 32'h12345678, 1'b1, 1);
    run_div("max_1", 32'hFFFFFFFF, 32'd1,
            32'hFFFFFFFF, 32'd0, 1'b0, 33);
    run_div("small", 32'd5, 32'd10, 32'd0, 32'd5, 1'b0, 33);
    run_div("max_max", 32'hFFFFFFFF, 32'hFFFFFFFF,
            32'd1, 32'd0, 1'b0, 33);
    run_div("hex", 32'h12345678, 32'h1000,
            32'h00012345, 32'h678, 1'b0, 33);
    run_div("d1e6_999", 32'd1000000, 32'd999,
            32'd1001, 32'd1, 1'b0, 33);
`endif

    // Start held high, operands change every cycle
    got  = 0;
    cyc  = 0;
    last = -1;
    @(negedge clk);
    start = 1'b1;
    while (got < 3 && cyc < 200) begin
      if (out_valid && ea.size() > 0) begin
        xa = ea.pop_front();
        xb = eb.pop_front();
        chk("b2b_q", quotient, xa / xb);
        chk("b2b_r", remainder, xa % xb);
        if (last >= 0) chk("b2b_period", cyc - last, 34);
        last = cyc;
        got++;
      end
      dividend = 32'd5000 + 32'(cyc * 13);
      divisor  = 32'd3 + 32'(cyc);
      if (!busy) begin
        ea.push_back(dividend);
        eb.push_back(divisor);
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_count", got, 3);
    repeat (40) @(negedge clk);

    // Reset during iteration 10
    start    = 1'b1;
    dividend = 32'hFFFFFFFF;
    divisor  = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_q", quotient, 32'd0);
    chk("mid_rst_r", remainder, 32'd0);
    chk("mid_rst_dz", {31'b0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid_rst_no_valid", seen, 0);
    run_div("after_rst", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width in bits (legal: even, 4..32).
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-004 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend, input, WIDTH, numerator; captured when start is accepted.
REQ-006 SHALL have port divisor, input, WIDTH, denominator; captured when start is accepted.
REQ-007 SHALL have port busy, output, 1, high in every state other than IDLE.
REQ-008 SHALL have port out_valid, output, 1, one-cycle pulse when quotient/remainder are valid.
REQ-009 SHALL have port quotient, output, WIDTH, result; held until the next accepted start.
REQ-010 SHALL have port remainder, output, WIDTH, result; held until the next accepted start.
REQ-011 SHALL have port div_by_zero, output, 1, flag qualified by out_valid; held with the results.

Function
REQ-012 SHALL implement states IDLE, CALC, DONE; IDLE->CALC on start with nonzero divisor; IDLE->DONE on start with zero divisor; CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-013 SHALL perform one restoring-division step per CALC cycle: shift {partial remainder, dividend} left by 1, trial-subtract the divisor, keep the difference and shift in quotient bit 1 if it is non-negative, else restore and shift in 0.
REQ-014 SHALL use a single WIDTH+1-bit add/subtract datapath for the trial subtraction, with subtract selected by carry-in = 1 and the b operand inverted.
REQ-015 SHALL, for a nonzero divisor, assert out_valid in the cycle following the (WIDTH+1)th rising edge after the edge that accepted start; latency is 33 cycles for WIDTH=32.
REQ-016 SHALL, for a zero divisor, assert out_valid in the cycle following the first edge after acceptance, with quotient = all ones, remainder = dividend and div_by_zero = 1.
REQ-017 SHALL ignore start while busy; accept start in IDLE on the edge following a DONE cycle, so back-to-back operation has exactly one idle cycle.
REQ-018 SHALL keep out_valid low in every cycle except DONE; busy SHALL be high in CALC and DONE.
REQ-019 SHALL update quotient, remainder and div_by_zero only on entry to DONE; they SHALL be stable at all other times.
REQ-020 SHALL ignore input changes after acceptance; dividend and divisor are sampled only on the accept edge.

Reset
REQ-021 SHALL, on rst high at any time including mid-CALC, immediately force state IDLE, busy 0, out_valid 0, quotient 0, remainder 0, div_by_zero 0, and iteration counter 0.
REQ-022 SHALL not accept start while rst is high; the first accept is on the first rising edge with rst low.

Configuration
REQ-023 SHALL support macro DIV_SIGNED_EN.
- Defined: operands are two's complement. Magnitudes are divided; the quotient is negated if the operand signs differ (truncation toward zero); the remainder takes the dividend's sign.
- Defined, divide by zero: quotient = 0x7FFFFFFF for a non-negative dividend, 0x80000000 for a negative dividend.
- Defined, most-negative / -1: quotient = most-negative value, remainder 0, div_by_zero 0.
- Defined, latency: unchanged.
- Undefined: operands and results are unsigned. No sign logic is synthesized; REQ-016 values apply.

Verification
REQ-024 SHALL cover: unsigned, 100 / 7 -> 33 cycles later out_valid=1, quotient=14, remainder=2, div_by_zero=0.
REQ-025 SHALL cover: divisor 0, dividend 0x12345678 -> out_valid on the 2nd cycle, quotient=0xFFFFFFFF (unsigned build), remainder=0x12345678, div_by_zero=1.
REQ-026 SHALL cover: DIV_SIGNED_EN defined, -7 / 2 -> quotient=-3 (0xFFFFFFFD), remainder=-1 (0xFFFFFFFF); also 0x80000000 / -1 -> quotient=0x80000000, remainder=0.
REQ-027 SHALL cover: start held high continuously with new operands each cycle -> exactly one result per 34 cycles, each matching the operands present on its accept edge.
REQ-028 SHALL cover: rst pulsed at iteration 10 of 0xFFFFFFFF / 3 -> all outputs 0 immediately and no out_valid; a new 9 / 3 then yields 3 r 0 after 33 cycles.
